fetch_line_queue: RTL and testbench

- Instruction-fetch byte queue directly downstream of the memory arbiter.
- Issues line-aligned fetch requests to the arbiter (`fetch_ad`, `send_fetch_req_in`).
- Captures each completed 64-byte `mem_buffer` line into a 2-line circular byte buffer.
- Presents a sliding window of the next instruction bytes to the decoder, which consumes a variable byte count per cycle. Handles redirects, including discarding an in-flight line.

---
 rtl/fetch_line_queue_if.sv | 37 +++
 rtl/fetch_line_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_line_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_line_queue_if.sv
// ============================================================================
// Module      : fetch_line_queue_if
// Description : Arbiter and decoder handshake bundle for the fetch byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_line_queue_if #(
    parameter int LINE_BYTES = 64,
    parameter int WIN_BYTES  = 16
);
    localparam int c_WCNT_W = $clog2(WIN_BYTES + 1);

    logic [63:0]               fetch_ad;
    logic                      send_fetch_req;
    logic                      mem_req_completed;
    logic [LINE_BYTES*8-1:0]   mem_buffer;
    logic                      redirect_valid;
    logic [63:0]               redirect_pc;
    logic [WIN_BYTES*8-1:0]    win_data;
    logic [c_WCNT_W-1:0]       win_count;
    logic [63:0]               win_pc;
    logic [c_WCNT_W-1:0]       consume;

    // Queue-side view: drives requests and the decoder window.
    modport master (
        output fetch_ad, send_fetch_req, win_data, win_count, win_pc,
        input  mem_req_completed, mem_buffer, redirect_valid, redirect_pc, consume
    );

    modport slave (
        input  fetch_ad, send_fetch_req, win_data, win_count, win_pc,
        output mem_req_completed, mem_buffer, redirect_valid, redirect_pc, consume
    );
endinterface

`default_nettype wire

// File: rtl/fetch_line_queue.sv
// ============================================================================
// Module      : fetch_line_queue
// Description : Line-fetching circular byte queue feeding a sliding decode window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_line_queue #(
    parameter int          LINE_BYTES = 64,
    parameter int          BUF_LINES  = 2,
    parameter int          WIN_BYTES  = 16,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fetch_line_queue_if.master bus
);

    localparam int          c_BUF_BYTES = LINE_BYTES * BUF_LINES;
    localparam int          c_PTR_W     = $clog2(c_BUF_BYTES);
    localparam int          c_CNT_W     = c_PTR_W + 1;
    localparam int          c_OFF_W     = $clog2(LINE_BYTES);
    localparam int          c_SLOT_W    = $clog2(BUF_LINES);
    localparam int          c_WCNT_W    = $clog2(WIN_BYTES + 1);
    localparam logic [63:0] c_LINE_MASK = ~64'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [c_CNT_W-1:0]  count_q,      count_d;
    logic [c_PTR_W-1:0]  head_q,       head_d;
    logic [c_SLOT_W-1:0] tail_q,       tail_d;
    logic                drop_q,       drop_d;
    logic [63:0]         fetch_line_q, fetch_line_d;
    logic [c_OFF_W-1:0]  skip_q,       skip_d;
    logic [63:0]         win_pc_q,     win_pc_d;

    logic [7:0]          mem_q [c_BUF_BYTES];

    logic                w_line_fill;
    logic                w_line_we;
    logic [c_CNT_W-1:0]  w_fill_bytes;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        drop_d       = drop_q;
        fetch_line_d = fetch_line_q;
        skip_d       = skip_q;
        win_pc_d     = win_pc_q;
        w_line_we    = 1'b0;

        w_line_fill  = (state_q == ST_WAIT) && bus.mem_req_completed;
        w_fill_bytes = c_CNT_W'(LINE_BYTES) - c_CNT_W'(skip_q);

        case (state_q)
            ST_IDLE: begin
                if (!bus.redirect_valid && !drop_q &&
                    (count_q <= c_CNT_W'(c_BUF_BYTES - LINE_BYTES))) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.mem_req_completed) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.redirect_valid) begin
            // The line still in flight belongs to the old stream; mark it for discard.
            count_d      = '0;
            head_d       = c_PTR_W'(bus.redirect_pc[c_OFF_W-1:0]);
            tail_d       = '0;
            skip_d       = bus.redirect_pc[c_OFF_W-1:0];
            win_pc_d     = bus.redirect_pc;
            fetch_line_d = bus.redirect_pc & c_LINE_MASK;
            drop_d       = (state_q == ST_REQ) || ((state_q == ST_WAIT) && !bus.mem_req_completed);
        end else begin
            w_line_we = w_line_fill && !drop_q;
            if (w_line_we) begin
                tail_d       = tail_q + 1'b1;
                fetch_line_d = fetch_line_q + 64'(LINE_BYTES);
                skip_d       = '0;
            end
            count_d  = count_q + (w_line_we ? w_fill_bytes : '0) - c_CNT_W'(bus.consume);
            head_d   = head_q + c_PTR_W'(bus.consume);
            win_pc_d = win_pc_q + 64'(bus.consume);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            head_q       <= c_PTR_W'(RESET_PC[c_OFF_W-1:0]);
            tail_q       <= '0;
            drop_q       <= 1'b0;
            fetch_line_q <= RESET_PC & c_LINE_MASK;
            skip_q       <= RESET_PC[c_OFF_W-1:0];
            win_pc_q     <= RESET_PC;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            drop_q       <= drop_d;
            fetch_line_q <= fetch_line_d;
            skip_q       <= skip_d;
            win_pc_q     <= win_pc_d;
        end
    end

    // Storage is deliberately left unreset; bytes outside count are never shown.
    always_ff @(posedge clk) begin
        if (w_line_we) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                mem_q[{tail_q, c_OFF_W'(k)}] <= bus.mem_buffer[k*8 +: 8];
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < WIN_BYTES; gi++) begin : g_win
        assign bus.win_data[gi*8 +: 8] = mem_q[head_q + c_PTR_W'(gi)];
    end

    assign bus.win_count      = (count_q > c_CNT_W'(WIN_BYTES)) ? c_WCNT_W'(WIN_BYTES)
                                                                : c_WCNT_W'(count_q);
    assign bus.win_pc         = win_pc_q;
    assign bus.fetch_ad       = fetch_line_q;
    assign bus.send_fetch_req = (state_q == ST_REQ);

endmodule

`default_nettype wire

// File: tb/tb_fetch_line_queue.sv
// ============================================================================
// Module      : tb_fetch_line_queue
// Description : Directed cycle-table bench for fetch_line_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_line_queue;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_line_queue_if #(.LINE_BYTES(64), .WIN_BYTES(16)) bus ();

    fetch_line_queue #(
        .LINE_BYTES (64),
        .BUF_LINES  (2),
        .WIN_BYTES  (16),
        .RESET_PC   (64'h1004)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One record per cycle: outputs expected at the negedge, then inputs driven.
    typedef struct {
        logic        cmp;
        logic [4:0]  cons;
        logic        redir;
        logic [63:0] rpc;
        logic        exp_send;
        logic [63:0] exp_ad;
        int          exp_cnt;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t        vecs[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] last_req = 64'h0;

    function automatic void add(input logic cmp, input int cons, input logic redir,
                                input logic [63:0] rpc, input logic esend,
                                input logic [63:0] ead, input int ecnt, input logic [63:0] epc);
        vec_t v;
        v.cmp = cmp; v.cons = 5'(cons); v.redir = redir; v.rpc = rpc;
        v.exp_send = esend; v.exp_ad = ead; v.exp_cnt = ecnt; v.exp_pc = epc;
        vecs.push_back(v);
    endfunction

    // Memory line pattern: every byte equals the low 8 bits of its own address.
    function automatic logic [511:0] line_data(input logic [63:0] a);
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[k*8 +: 8] = 8'(a + 64'(k));
        return d;
    endfunction

    task automatic check(input string tag, input logic esend, input logic [63:0] ead,
                         input int ecnt, input logic [63:0] epc);
        logic [7:0] got_b;
        logic [7:0] exp_b;
        n_vec++;
        if (bus.send_fetch_req !== esend) begin
            n_miss++;
            $display("FAIL %s send_fetch_req got %0b want %0b", tag, bus.send_fetch_req, esend);
        end
        if (bus.fetch_ad !== ead) begin
            n_miss++;
            $display("FAIL %s fetch_ad got %h want %h", tag, bus.fetch_ad, ead);
        end
        if (bus.win_count !== 5'(ecnt)) begin
            n_miss++;
            $display("FAIL %s win_count got %0d want %0d", tag, bus.win_count, ecnt);
        end
        if (bus.win_pc !== epc) begin
            n_miss++;
            $display("FAIL %s win_pc got %h want %h", tag, bus.win_pc, epc);
        end
        if (ecnt > 0) begin
            got_b = bus.win_data[7:0];
            exp_b = epc[7:0];
            if (got_b !== exp_b) begin
                n_miss++;
                $display("FAIL %s win_data[0] got %h want %h", tag, got_b, exp_b);
            end
            got_b = bus.win_data[(ecnt-1)*8 +: 8];
            exp_b = 8'(epc + 64'(ecnt - 1));
            if (got_b !== exp_b) begin
                n_miss++;
                $display("FAIL %s win_data[%0d] got %h want %h", tag, ecnt - 1, got_b, exp_b);
            end
        end
    endtask

    task automatic drive(input logic cmp, input logic [4:0] cons, input logic redir,
                         input logic [63:0] rpc);
        if (cons > bus.win_count) begin
            n_miss++;
            $display("FAIL consume_guard consume %0d exceeds win_count %0d", cons, bus.win_count);
        end
        bus.mem_req_completed = cmp;
        bus.mem_buffer        = cmp ? line_data(last_req) : '0;
        bus.consume           = cons;
        bus.redirect_valid    = redir;
        bus.redirect_pc       = rpc;
    endtask

    initial begin
        bus.mem_req_completed = 1'b0;
        bus.mem_buffer        = '0;
        bus.consume           = '0;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = '0;

        //   cmp cons rd rpc         send ad         cnt pc
        add(0,  0, 0, 64'h0,    1, 64'h1000,  0, 64'h1004);
        add(1,  0, 0, 64'h0,    0, 64'h1000,  0, 64'h1004);
        add(0,  0, 0, 64'h0,    0, 64'h1040, 16, 64'h1004);
        add(0,  0, 0, 64'h0,    1, 64'h1040, 16, 64'h1004);
        add(1,  0, 0, 64'h0,    0, 64'h1040, 16, 64'h1004);
        add(0,  0, 0, 64'h0,    0, 64'h1080, 16, 64'h1004);
        add(0, 16, 0, 64'h0,    0, 64'h1080, 16, 64'h1004);
        add(0, 16, 0, 64'h0,    0, 64'h1080, 16, 64'h1014);
        add(0, 16, 0, 64'h0,    0, 64'h1080, 16, 64'h1024);
        add(0, 16, 0, 64'h0,    0, 64'h1080, 16, 64'h1034);
        add(0,  0, 0, 64'h0,    0, 64'h1080, 16, 64'h1044);
        add(0, 13, 0, 64'h0,    1, 64'h1080, 16, 64'h1044);
        add(1, 13, 0, 64'h0,    0, 64'h1080, 16, 64'h1051);
        add(0, 13, 0, 64'h0,    0, 64'h10C0, 16, 64'h105E);
        add(0, 13, 0, 64'h0,    0, 64'h10C0, 16, 64'h106B);
        add(0, 13, 0, 64'h0,    0, 64'h10C0, 16, 64'h1078);
        add(0, 13, 0, 64'h0,    0, 64'h10C0, 16, 64'h1085);
        add(0, 13, 0, 64'h0,    1, 64'h10C0, 16, 64'h1092);
        add(1, 13, 0, 64'h0,    0, 64'h10C0, 16, 64'h109F);
        add(0, 13, 0, 64'h0,    0, 64'h1100, 16, 64'h10AC);
        add(0, 13, 0, 64'h0,    0, 64'h1100, 16, 64'h10B9);
        add(0,  0, 0, 64'h0,    0, 64'h1100, 16, 64'h10C6);
        add(0,  0, 0, 64'h0,    1, 64'h1100, 16, 64'h10C6);
        add(0,  5, 1, 64'h2021, 0, 64'h1100, 16, 64'h10C6);
        add(1,  0, 0, 64'h0,    0, 64'h2000,  0, 64'h2021);
        add(0,  0, 0, 64'h0,    0, 64'h2000,  0, 64'h2021);
        add(0,  0, 0, 64'h0,    1, 64'h2000,  0, 64'h2021);
        add(1,  0, 0, 64'h0,    0, 64'h2000,  0, 64'h2021);
        add(0,  0, 0, 64'h0,    0, 64'h2040, 16, 64'h2021);
        add(0, 11, 0, 64'h0,    1, 64'h2040, 16, 64'h2021);
        add(1, 10, 0, 64'h0,    0, 64'h2040, 16, 64'h202C);
        add(0, 10, 0, 64'h0,    0, 64'h2080, 16, 64'h2036);
        add(0,  0, 0, 64'h0,    0, 64'h2080, 16, 64'h2040);
        add(0,  0, 0, 64'h0,    1, 64'h2080, 16, 64'h2040);
        add(0,  0, 0, 64'h0,    0, 64'h2080, 16, 64'h2040);

        repeat (3) @(negedge clk);
        check("reset_values", 1'b0, 64'h1000, 0, 64'h1004);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp_send, vecs[i].exp_ad,
                  vecs[i].exp_cnt, vecs[i].exp_pc);
            if (vecs[i].exp_send) last_req = vecs[i].exp_ad;
            drive(vecs[i].cmp, vecs[i].cons, vecs[i].redir, vecs[i].rpc);
        end

        // Asynchronous reset while waiting on a line, then a stale completion.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset", 1'b0, 64'h1000, 0, 64'h1004);
        drive(1'b1, 5'd0, 1'b0, 64'h0);
        @(negedge clk);
        check("reset_held", 1'b0, 64'h1000, 0, 64'h1004);
        reset = 1'b1;
        @(negedge clk);
        check("stale_cmp_ignored", 1'b1, 64'h1000, 0, 64'h1004);
        last_req = 64'h1000;
        drive(1'b0, 5'd0, 1'b0, 64'h0);

        // Redirect coincident with completion: data dropped, no pending discard.
        @(negedge clk);
        check("wait_before_redir", 1'b0, 64'h1000, 0, 64'h1004);
        drive(1'b1, 5'd0, 1'b1, 64'h2035);
        @(negedge clk);
        check("redir_with_cmp", 1'b0, 64'h2000, 0, 64'h2035);
        drive(1'b0, 5'd0, 1'b0, 64'h0);
        @(negedge clk);
        check("req_after_redir", 1'b1, 64'h2000, 0, 64'h2035);
        last_req = 64'h2000;
        @(negedge clk);
        check("wait_2000", 1'b0, 64'h2000, 0, 64'h2035);
        drive(1'b1, 5'd0, 1'b0, 64'h0);
        @(negedge clk);
        check("partial_window", 1'b0, 64'h2040, 11, 64'h2035);
        drive(1'b0, 5'd0, 1'b0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
